// File: rtl/serial_link_pkg.sv
// Shared types and line constants for the serial link receive path.
// Parity helpers are used only when SERIAL_LINK_RX_PARITY_EN is defined.
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Even parity: running XOR of the data bits plus the parity bit must be zero.
  function automatic logic parity_ok(input logic data_xor, input logic par_bit);
    return (data_xor ^ par_bit) == 1'b0;
  endfunction

endpackage

// File: rtl/serial_link_rx_if.sv
// Consumer-side word port of the serial link receiver.
interface serial_link_rx_if #(
  parameter int DATA_W = 8
);
  // Valid/ready: a word transfers on a clk edge where rx_valid && rx_ready.
  // Once rx_valid is high, rx_data and rx_valid hold until that transfer.
  // rx_valid never waits on rx_ready; rx_ready may depend on rx_valid.
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/serial_link_rx_buf.sv
// Two-entry in-order word buffer between the receive FSM and the consumer.
// A push while full is accepted only if a pop happens in the same cycle.
module serial_link_rx_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_link_rx.sv
// Serial link receiver: start detect, LSB-first deserialise, stop check, 2-word buffer.
// Optional even parity bit after the data when SERIAL_LINK_RX_PARITY_EN is defined.
module serial_link_rx
  import serial_link_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_i,
  serial_link_rx_if.master  rx_if,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun_err,
  output logic              busy,
  output rx_state_e         state_o
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CYC_MID  = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  rx_state_e         state_q;
  logic              line_q;
  logic [CW-1:0]     cyc_cnt_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              frame_err_q;
  logic              overrun_err_q;

  logic              sample;
  logic              word_done;
  logic              push;
  logic              pop;
  logic              buf_full;
  logic              buf_empty;

  // The start bit is checked half a bit in; every later bit one full bit after that.
  assign sample    = (state_q == START) ? (cyc_cnt_q == CYC_MID) : (cyc_cnt_q == CYC_LAST);
  assign word_done = (state_q == STOP) && sample && (line_i == STOP_BIT);
  assign pop       = rx_if.rx_valid && rx_if.rx_ready;

`ifdef SERIAL_LINK_RX_PARITY_EN
  logic par_acc_q;
  logic par_bad_q;
  logic parity_err_q;

  assign push       = word_done && !par_bad_q;
  assign parity_err = parity_err_q;
`else
  assign push       = word_done;
  assign parity_err = 1'b0;
`endif

  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != IDLE);
  assign state_o     = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      line_q        <= LINE_IDLE;
      cyc_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef SERIAL_LINK_RX_PARITY_EN
      par_acc_q     <= 1'b0;
      par_bad_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      line_q        <= line_i;
      frame_err_q   <= 1'b0;
      overrun_err_q <= push && buf_full && !pop;
`ifdef SERIAL_LINK_RX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (line_q == LINE_IDLE && line_i == START_BIT) begin
            state_q   <= START;
            cyc_cnt_q <= '0;
          end
        end
        START: begin
          if (sample) begin
            cyc_cnt_q <= '0;
            bit_cnt_q <= '0;
`ifdef SERIAL_LINK_RX_PARITY_EN
            par_acc_q <= 1'b0;
`endif
            // A start bit that has already gone high was a glitch.
            state_q   <= (line_i == START_BIT) ? DATA : IDLE;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (sample) begin
            cyc_cnt_q <= '0;
            shift_q   <= {line_i, shift_q[DATA_W-1:1]};
            bit_cnt_q <= bit_cnt_q + BW'(1);
`ifdef SERIAL_LINK_RX_PARITY_EN
            par_acc_q <= par_acc_q ^ line_i;
            if (bit_cnt_q == BIT_LAST) state_q <= PARITY;
`else
            if (bit_cnt_q == BIT_LAST) state_q <= STOP;
`endif
          end else begin
            cyc_cnt_q <= cyc_cnt_q + CW'(1);
          end
        end
`ifdef SERIAL_LINK_RX_PARITY_EN
        PARITY: begin
          if (sample) begin
            cyc_cnt_q <= '0;
            par_bad_q <= !parity_ok(par_acc_q, line_i);
            state_q   <= STOP;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + CW'(1);
          end
        end
`endif
        STOP: begin
          if (sample) begin
            cyc_cnt_q <= '0;
            if (line_i == STOP_BIT) begin
`ifdef SERIAL_LINK_RX_PARITY_EN
              parity_err_q <= par_bad_q;
`endif
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end else begin
            cyc_cnt_q <= cyc_cnt_q + CW'(1);
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) must not look like a fresh start bit.
          if (line_i == LINE_IDLE) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  serial_link_rx_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (pop),
    .data_o      (rx_if.rx_data),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  assign rx_if.rx_valid = !buf_empty;

endmodule

// File: tb/tb_serial_link_rx.sv
// Self-checking bench for serial_link_rx (DATA_W=8, BIT_CYCLES=4).
// Parity cases are included when SERIAL_LINK_RX_PARITY_EN is defined.
module tb_serial_link_rx;
  import serial_link_pkg::*;

  localparam int DATA_W     = 8;
  localparam int BIT_CYCLES = 4;

  logic      clk;
  logic      reset_n;
  logic      line_i;
  logic      frame_err;
  logic      parity_err;
  logic      overrun_err;
  logic      busy;
  rx_state_e dut_state;

  serial_link_rx_if #(.DATA_W(DATA_W)) rx_if ();

  serial_link_rx #(
    .DATA_W     (DATA_W),
    .BIT_CYCLES (BIT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .line_i      (line_i),
    .rx_if       (rx_if),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err),
    .busy        (busy),
    .state_o     (dut_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int frame_cnt = 0;
  int par_cnt = 0;
  int ovr_cnt = 0;
  int exp_frame = 0;
  int exp_par = 0;
  int exp_ovr = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks: each starts and ends just after a rising edge
  task automatic drive_bit(input logic b);
    line_i = b;
    repeat (BIT_CYCLES) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] data, input logic stop_b,
                            input logic par_flip, input bit chk_lat);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) drive_bit(data[i]);
`ifdef SERIAL_LINK_RX_PARITY_EN
    drive_bit((^data) ^ par_flip);
`endif
    line_i = stop_b;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (chk_lat) check_eq("valid_before_stop_sample", rx_if.rx_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    if (chk_lat) check_eq("valid_after_stop_sample", rx_if.rx_valid, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic check_pulses(input string tag);
    check_eq({tag, "_frame_err"}, frame_cnt, exp_frame);
    check_eq({tag, "_parity_err"}, par_cnt, exp_par);
    check_eq({tag, "_overrun_err"}, ovr_cnt, exp_ovr);
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_err) frame_cnt++;
      if (parity_err) par_cnt++;
      if (overrun_err) ovr_cnt++;
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_word", rx_if.rx_data, 32'hFFFF_FFFF);
        end else begin
          check_eq("rx_data", rx_if.rx_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] d;
    reset_n = 1'b0;
    line_i = 1'b1;
    rx_if.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", rx_if.rx_valid, 1'b0);
    check_eq("rst_data", rx_if.rx_data, 0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_state", dut_state, IDLE);
    check_eq("rst_pulses", {frame_err, parity_err, overrun_err}, 3'b000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive_bit(1'b1);

    // 1: clean word with latency check
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1);
    drain("t1_drain");
    check_pulses("t1");

    // 2: one-clock glitch
    line_i = 1'b0;
    @(posedge clk);
    #1;
    line_i = 1'b1;
    @(negedge clk);
    check_eq("t2_busy_start", busy, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("t2_busy_idle", busy, 1'b0);
    check_eq("t2_valid", rx_if.rx_valid, 1'b0);
    drive_bit(1'b1);
    check_pulses("t2");

    // 3: bad stop bit, line held low, then recovery
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    exp_frame++;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("t3_wait_idle", dut_state, WAIT_IDLE);
    @(posedge clk);
    #1;
    line_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("t3_busy_after_break", busy, 1'b0);
    check_eq("t3_no_word", rx_if.rx_valid, 1'b0);
    @(posedge clk);
    #1;
    drive_bit(1'b1);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1);
    drain("t3_drain");
    check_pulses("t3");

    // 4: consumer stalled, third word overruns
    rx_if.rx_ready = 1'b0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1);
    send_frame(8'h02, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1);
    send_frame(8'h03, 1'b1, 1'b0, 1'b0);
    exp_ovr++;
    drive_bit(1'b1);
    @(negedge clk);
    check_eq("t4_stall_valid", rx_if.rx_valid, 1'b1);
    check_eq("t4_stall_data", rx_if.rx_data, 8'h01);
    check_pulses("t4");
    @(posedge clk);
    #1;
    rx_if.rx_ready = 1'b1;
    drain("t4_drain");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("t4_empty", rx_if.rx_valid, 1'b0);
    @(posedge clk);
    #1;

`ifdef SERIAL_LINK_RX_PARITY_EN
    // 5: parity error, then correct parity
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    exp_par++;
    drive_bit(1'b1);
    check_eq("t5_no_word", rx_if.rx_valid, 1'b0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1);
    drain("t5_drain");
    check_pulses("t5");
`endif

    // 6: reset in the middle of the data bits
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    check_eq("t6_busy_mid", busy, 1'b1);
    reset_n = 1'b0;
    line_i = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_busy", busy, 1'b0);
    check_eq("t6_rst_valid", rx_if.rx_valid, 1'b0);
    check_eq("t6_rst_data", rx_if.rx_data, 0);
    check_eq("t6_rst_state", dut_state, IDLE);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive_bit(1'b1);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b1);
    drain("t6_drain");
    check_pulses("t6");

    // random back-to-back words
    for (int n = 0; n < 8; n++) begin
      d = DATA_W'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_frame(d, 1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) drive_bit(1'b1);
    end
    drive_bit(1'b1);
    drain("rand_drain");
    check_pulses("rand");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule
